fp32_to_int32_sched: RTL and testbench

// Round-robin scheduler that shares one combinational fp32_to_int32 converter among
// N_REQ requesters. It arbitrates valid/ready requests, converts one operand per cycle
// and registers the result with a requester ID and status flags. It applies back-pressure

---
 rtl/fp32_to_int32_sched.sv | 124 ++++++++++++
 tb/tb_fp32_to_int32_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp32_to_int32_sched: round-robin sharing of one fp32->int32 converter
// Rev 1.0
// ----------------------------------------------------------------------------
module fp32_to_int32_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_nan,
  output logic                  out_sat,
  output logic [CNT_W-1:0]      sat_count,
  input  logic                  clr_count
);

  logic [ID_W-1:0] ptr;
  logic            stage_free;
  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] ptr_next;
  logic [31:0]     sel_data;
  logic [31:0]     conv_data;
  logic            conv_nan;
  logic            conv_sat;
  int              idx;

  assign stage_free = !out_valid || out_ready;

  // First valid requester at or after ptr, wrapping; nothing granted in reset.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    if (!stage_free || rst) grant_any = 1'b0;
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign sel_data = req_data[32*grant_idx +: 32];
  assign ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

  logic        sgn;
  logic [7:0]  ex;
  logic [22:0] man;
  logic [7:0]  e_unb;
  logic [31:0] mag;

  assign sgn = sel_data[31];
  assign ex  = sel_data[30:23];
  assign man = sel_data[22:0];

  // Unbiased exponent above 30 also catches -2^31, which is flagged saturated.
  always_comb begin
    conv_data = '0;
    conv_nan  = 1'b0;
    conv_sat  = 1'b0;
    mag       = '0;
    e_unb     = ex - 8'd127;
    if (ex == 8'hFF) begin
      if (man != '0) begin
        conv_nan = 1'b1;
      end else begin
        conv_sat  = 1'b1;
        conv_data = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (ex >= 8'd127) begin
      if (e_unb > 8'd30) begin
        conv_sat  = 1'b1;
        conv_data = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        if (e_unb >= 8'd23) mag = {8'd0, 1'b1, man} << (e_unb - 8'd23);
        else                mag = {8'd0, 1'b1, man} >> (8'd23 - e_unb);
        conv_data = sgn ? -mag : mag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_nan   <= 1'b0;
      out_sat   <= 1'b0;
      sat_count <= '0;
      ptr       <= '0;
    end else begin
      if (stage_free) begin
        out_valid <= grant_any;
        if (grant_any) begin
          out_data <= conv_data;
          out_id   <= grant_idx;
          out_nan  <= conv_nan;
          out_sat  <= conv_sat;
          ptr      <= ptr_next;
        end
      end
      if (clr_count)
        sat_count <= '0;
      else if (out_valid && out_ready && out_sat && (sat_count != '1))
        sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int32_sched.sv
`default_nettype none
// Bench for fp32_to_int32_sched: vector table, scoreboard and corner sequences.
module tb_fp32_to_int32_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic         out_nan;
  logic         out_sat;
  logic [15:0]  sat_count;
  logic         clr_count = 1'b0;

  logic [3:0]   s_req_valid = 4'b0001;
  logic [3:0]   s_req_ready;
  logic [127:0] s_req_data = {96'd0, 32'h4F00_0000};
  logic         s_out_valid;
  logic [31:0]  s_out_data;
  logic [1:0]   s_out_id;
  logic         s_out_nan;
  logic         s_out_sat;
  logic [1:0]   s_sat_count;

  always #5 clk = ~clk;

  fp32_to_int32_sched #(.N_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_nan(out_nan), .out_sat(out_sat),
    .sat_count(sat_count), .clr_count(clr_count)
  );

  fp32_to_int32_sched #(.N_REQ(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_data(s_req_data), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_data(s_out_data), .out_id(s_out_id), .out_nan(s_out_nan), .out_sat(s_out_sat),
    .sat_count(s_sat_count), .clr_count(1'b0)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic        nan;
    logic        sat;
  } res_t;

  typedef struct {
    int          req;
    logic [31:0] din;
    logic [31:0] dout;
    logic        nan;
    logic        sat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  res_t        sb[$];
  logic [31:0] cur_data[4];
  logic        cur_nan[4];
  logic        cur_sat[4];
  vec_t        tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] d, input logic [31:0] e,
                         input logic n, input logic s);
    req_data[32*r +: 32] = d;
    cur_data[r] = e;
    cur_nan[r]  = n;
    cur_sat[r]  = s;
  endtask

  // Scoreboard: push on request transfer, pop on output handshake.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got id %0d data %h expected none", out_id, out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_id", {30'd0, out_id}, {30'd0, e.id});
          chk("sb_nan", {31'd0, out_nan}, {31'd0, e.nan});
          chk("sb_sat", {31'd0, out_sat}, {31'd0, e.sat});
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.data = cur_data[i];
          e.id   = 2'(i);
          e.nan  = cur_nan[i];
          e.sat  = cur_sat[i];
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{0, 32'h406C_CCCD, 32'h0000_0003, 1'b0, 1'b0};
    tbl[1]  = '{1, 32'h7FC0_0000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{2, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{3, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4]  = '{0, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[5]  = '{1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b1};
    tbl[6]  = '{2, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[7]  = '{3, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
    tbl[8]  = '{0, 32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0};
    tbl[9]  = '{1, 32'h3F7F_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    tbl[10] = '{2, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    tbl[11] = '{3, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    tbl[12] = '{0, 32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[13] = '{1, 32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0};
    tbl[14] = '{2, 32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b0};
    tbl[15] = '{3, 32'h7F80_0001, 32'h0000_0000, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) set_req(i, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset state, with requests pending to show req_ready is suppressed.
    rst = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_id", {30'd0, out_id}, 32'd0);
    chk("rst_flags", {30'd0, out_nan, out_sat}, 32'd0);
    chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = 4'b0000;
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      set_req(tbl[i].req, tbl[i].din, tbl[i].dout, tbl[i].nan, tbl[i].sat);
      req_valid = 4'b0001 << tbl[i].req;
      #1;
      chk("vec_req_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << tbl[i].req});
      step();
      req_valid = 4'b0000;
      chk("vec_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_data", out_data, tbl[i].dout);
      chk("vec_id", {30'd0, out_id}, tbl[i].req);
      chk("vec_flags", {30'd0, out_nan, out_sat}, {30'd0, tbl[i].nan, tbl[i].sat});
      step();
    end
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("table_sat_count", {16'd0, sat_count}, 32'd4);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    chk("clr_sat_count", {16'd0, sat_count}, 32'd0);

    // Fairness: all valid, ptr is 0 after the table ended on requester 3.
    for (int i = 0; i < 4; i++)
      set_req(i, 32'h3F80_0000 + (32'(i == 0 ? 0 : 0)), 32'd0, 1'b0, 1'b0);
    set_req(0, 32'h3F80_0000, 32'd1, 1'b0, 1'b0);
    set_req(1, 32'h4000_0000, 32'd2, 1'b0, 1'b0);
    set_req(2, 32'h4040_0000, 32'd3, 1'b0, 1'b0);
    set_req(3, 32'h4080_0000, 32'd4, 1'b0, 1'b0);
    req_valid = 4'b1111;
    #1;
    chk("rr_first_ready", {28'd0, req_ready}, 32'h1);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("rr_valid", {31'd0, out_valid}, 32'd1);
      chk("rr_id", {30'd0, out_id}, k % 4);
      chk("rr_data", out_data, (k % 4) + 1);
    end

    // Back-pressure: hold the id-3 result for five cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_id", {30'd0, out_id}, 32'd3);
      chk("bp_data", out_data, 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, req_ready}, 32'h1);
    step();
    chk("bp_next_id", {30'd0, out_id}, 32'd0);
    chk("bp_next_data", out_data, 32'd1);
    req_valid = 4'b0000;
    step();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Three saturated deliveries, back to back.
    set_req(1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    req_valid = 4'b0010;
    step();
    step();
    step();
    req_valid = 4'b0000;
    step();
    chk("sat3_count", {16'd0, sat_count}, 32'd3);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    chk("clr_priority", {16'd0, sat_count}, 32'd0);

    // Reset while a result is stalled.
    set_req(2, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1);
    req_valid = 4'b0100;
    step();
    step();
    req_valid = 4'b0000;
    out_ready = 1'b0;
    step();
    chk("pre_rst_count", {16'd0, sat_count}, 32'd1);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    set_req(1, 32'h3F80_0000, 32'd1, 1'b0, 1'b0);
    set_req(3, 32'h4040_0000, 32'd3, 1'b0, 1'b0);
    rst = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("rst_mid_ready", {28'd0, req_ready}, 32'd0);
    step();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_count", {16'd0, sat_count}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", {28'd0, req_ready}, 32'h2);
    step();
    chk("post_rst_id", {30'd0, out_id}, 32'd1);
    step();
    chk("post_rst_id2", {30'd0, out_id}, 32'd3);
    req_valid = 4'b0000;
    step();
    step();

    chk("small_sat_sticky", {30'd0, s_sat_count}, 32'd3);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
